// File: rtl/huffman_packing_encoder.sv
// Huffman packing encoder: maps 4-bit symbols through a programmable code table
// and packs the codes MSB-first into 32-bit output words, with flush of a partial word.
module huffman_packing_encoder #(
  parameter int SYM_W  = 4,
  parameter int CODE_W = 16,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] in,
  input  logic              flush,
  input  logic              tbl_we,
  input  logic [SYM_W-1:0]  tbl_addr,
  input  logic [CODE_W-1:0] tbl_code,
  input  logic [4:0]        tbl_len,
  output logic              busy,
  output logic [WORD_W-1:0] output_data,
  output logic              output_ready,
  output logic [5:0]        output_bits,
  output logic              err
);

  localparam int NSYM  = WORD_W / SYM_W;
  localparam int NENT  = 2 ** SYM_W;
  localparam int ACC_W = 2 * WORD_W;
  localparam int K_W   = $clog2(NSYM);

  // Handshake: load/flush/tbl_we are single-cycle strobes sampled only while IDLE
  // (busy=0); output_ready is a one-cycle valid with no backpressure.
  typedef enum logic {IDLE, ENC} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   in_q, in_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q [NENT];
  logic [CODE_W-1:0]   code_d [NENT];
  logic [4:0]          len_q [NENT];
  logic [4:0]          len_d [NENT];
  logic [WORD_W-1:0]   output_data_q, output_data_d;
  logic [5:0]          output_bits_q, output_bits_d;
  logic                output_ready_q, output_ready_d;
  logic                err_q, err_d;

  logic [SYM_W-1:0]    sym;
  logic [CODE_W-1:0]   cur_code;
  logic [4:0]          cur_len;
  logic                len_ok;
  logic [CODE_W-1:0]   code_mask;
  logic [ACC_W-1:0]    app;
  logic [ACC_W-1:0]    acc_next;
  logic [6:0]          sum;

  always_comb begin
    state_d        = state_q;
    in_d           = in_q;
    k_d            = k_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    code_d         = code_q;
    len_d          = len_q;
    output_data_d  = output_data_q;
    output_bits_d  = output_bits_q;
    output_ready_d = 1'b0;
    err_d          = err_q;

    sym       = in_q[WORD_W-1 -: SYM_W];
    cur_code  = code_q[sym];
    cur_len   = len_q[sym];
    len_ok    = (cur_len != 5'd0) && (cur_len <= 5'(CODE_W));
    code_mask = '1;
    code_mask = code_mask >> (5'(CODE_W) - cur_len);
    // Left-align the masked code so its MSB lands just below the cnt valid bits.
    app       = {{(ACC_W-CODE_W){1'b0}}, cur_code & code_mask}
                << (7'(ACC_W) - cnt_q - {2'b00, cur_len});
    acc_next  = acc_q | app;
    sum       = cnt_q + {2'b00, cur_len};

    case (state_q)
      IDLE: begin
        if (load) begin
          in_d    = in;
          k_d     = '0;
          state_d = ENC;
        end else if (flush && (cnt_q != 7'd0)) begin
          output_data_d  = acc_q[ACC_W-1 -: WORD_W];
          output_bits_d  = cnt_q[5:0];
          output_ready_d = 1'b1;
          cnt_d          = 7'd0;
          acc_d          = '0;
        end
        if (tbl_we) begin
          code_d[tbl_addr] = tbl_code;
          len_d[tbl_addr]  = tbl_len;
        end
      end
      ENC: begin
        in_d = in_q << SYM_W;
        k_d  = k_q + K_W'(1);
        if (len_ok) begin
          if (sum >= 7'(WORD_W)) begin
            output_data_d  = acc_next[ACC_W-1 -: WORD_W];
            output_bits_d  = 6'(WORD_W);
            output_ready_d = 1'b1;
            acc_d          = acc_next << WORD_W;
            cnt_d          = sum - 7'(WORD_W);
          end else begin
            acc_d = acc_next;
            cnt_d = sum;
          end
        end else begin
          err_d = 1'b1;
        end
        if (k_q == K_W'(NSYM-1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      in_q           <= '0;
      k_q            <= '0;
      acc_q          <= '0;
      cnt_q          <= 7'd0;
      output_data_q  <= '0;
      output_bits_q  <= 6'd0;
      output_ready_q <= 1'b0;
      err_q          <= 1'b0;
      for (int i = 0; i < NENT; i++) begin
        code_q[i] <= '0;
        len_q[i]  <= 5'd0;
      end
    end else begin
      state_q        <= state_d;
      in_q           <= in_d;
      k_q            <= k_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      output_data_q  <= output_data_d;
      output_bits_q  <= output_bits_d;
      output_ready_q <= output_ready_d;
      err_q          <= err_d;
      for (int i = 0; i < NENT; i++) begin
        code_q[i] <= code_d[i];
        len_q[i]  <= len_d[i];
      end
    end
  end

  assign busy         = (state_q == ENC);
  assign output_data  = output_data_q;
  assign output_bits  = output_bits_q;
  assign output_ready = output_ready_q;
  assign err          = err_q;

endmodule

// File: tb/tb_huffman_packing_encoder.sv
// Bench for huffman_packing_encoder: directed scenarios plus randomized words,
// checked against a bit-queue reference model of the packing rules.
module tb_huffman_packing_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] in;
  logic        flush;
  logic        tbl_we;
  logic [3:0]  tbl_addr;
  logic [15:0] tbl_code;
  logic [4:0]  tbl_len;
  logic        busy;
  logic [31:0] output_data;
  logic        output_ready;
  logic [5:0]  output_bits;
  logic        err;

  int checks   = 0;
  int failures = 0;

  huffman_packing_encoder dut (
    .clk(clk), .rst(rst), .load(load), .in(in), .flush(flush),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code), .tbl_len(tbl_len),
    .busy(busy), .output_data(output_data), .output_ready(output_ready),
    .output_bits(output_bits), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: table, pending code bits as a plain bit queue, sticky error.
  logic [15:0] m_code [16];
  logic [4:0]  m_len  [16];
  bit          mq[$];
  bit          m_err;

  int          strobe_cnt;
  logic [31:0] last_data;
  logic [5:0]  last_bits;

  function automatic void model_reset();
    mq.delete();
    m_err = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_code[i] = '0;
      m_len[i]  = '0;
    end
  endfunction

  function automatic void model_sym(input logic [3:0] s);
    if (m_len[s] == 5'd0 || m_len[s] > 5'd16) begin
      m_err = 1'b1;
    end else begin
      for (int b = int'(m_len[s]) - 1; b >= 0; b--) mq.push_back(m_code[s][b]);
    end
  endfunction

  function automatic logic [31:0] model_pop_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      if (mq.size() > 0) w[31-i] = mq.pop_front();
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_tbl(input logic [3:0] a, input logic [15:0] c, input logic [4:0] l);
    tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l;
    tick();
    tbl_we = 1'b0;
    m_code[a] = c;
    m_len[a]  = l;
  endtask

  task automatic program_table();
    write_tbl(4'd0, 16'h0000, 5'd1);
    write_tbl(4'd1, 16'h0002, 5'd2);
    write_tbl(4'd2, 16'h0006, 5'd3);
    write_tbl(4'd3, 16'h000E, 5'd4);
    write_tbl(4'd4, 16'h00F4, 5'd8);
  endtask

  // Captures w, then walks the eight encode cycles comparing every cycle.
  // inject: hit load/flush/tbl_we mid-encode; with_flush: flush alongside load.
  task automatic encode_word(input logic [31:0] w, input bit inject, input bit with_flush);
    logic        exp_rdy;
    logic [31:0] exp_w;
    load = 1'b1; in = w; flush = with_flush;
    tick();
    load = 1'b0; flush = 1'b0;
    chk("busy_after_load", busy, 1);
    chk("rdy_after_load", output_ready, 0);
    for (int k = 0; k < 8; k++) begin
      if (inject && k == 2) begin
        load = 1'b1; in = 32'h11111111; flush = 1'b1;
        tbl_we = 1'b1; tbl_addr = 4'd0; tbl_code = 16'hFFFF; tbl_len = 5'd16;
      end
      tick();
      load = 1'b0; flush = 1'b0; tbl_we = 1'b0;
      model_sym(w[31-4*k -: 4]);
      exp_rdy = (mq.size() >= 32);
      chk("enc_ready", output_ready, exp_rdy);
      if (output_ready) begin
        strobe_cnt++;
        last_data = output_data;
        last_bits = output_bits;
      end
      if (exp_rdy) begin
        exp_w = model_pop_word();
        chk("enc_data", output_data, exp_w);
        chk("enc_bits", output_bits, 6'd32);
      end
      chk("enc_busy", busy, (k < 7));
      chk("enc_err", err, m_err);
    end
  endtask

  task automatic do_flush();
    int          n;
    logic [31:0] exp_w;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if (output_ready) begin
      strobe_cnt++;
      last_data = output_data;
      last_bits = output_bits;
    end
    if (mq.size() > 0) begin
      n     = mq.size();
      exp_w = model_pop_word();
      chk("flush_ready", output_ready, 1);
      chk("flush_data", output_data, exp_w);
      chk("flush_bits", output_bits, 6'(n));
    end else begin
      chk("flush_none", output_ready, 0);
    end
    tick();
    chk("flush_ready_drop", output_ready, 0);
  endtask

  initial begin
    logic [31:0] w;
    logic [3:0]  s;
    rst = 1'b1; load = 1'b0; in = '0; flush = 1'b0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0;
    strobe_cnt = 0; last_data = '0; last_bits = '0;
    model_reset();
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", output_ready, 0);
    chk("rst_data", output_data, 0);
    chk("rst_bits", output_bits, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();
    program_table();

    // All sym0: eight 1-bit zeros, drained by flush.
    strobe_cnt = 0;
    encode_word(32'h00000000, 1'b0, 1'b0);
    chk("t1_no_strobe", strobe_cnt, 0);
    do_flush();
    chk("t1_flush_data", last_data, 32'h00000000);
    chk("t1_flush_bits", last_bits, 6'd8);

    // Two words of sym1: one full word of "10" pairs at the last symbol.
    strobe_cnt = 0;
    encode_word(32'h11111111, 1'b0, 1'b0);
    chk("t2_first_none", strobe_cnt, 0);
    encode_word(32'h11111111, 1'b0, 1'b0);
    chk("t2_strobes", strobe_cnt, 1);
    chk("t2_data", last_data, 32'hAAAAAAAA);
    do_flush();
    chk("t2_after_flush", strobe_cnt, 1);

    // sym4 codes: strobes after symbols 3 and 7.
    strobe_cnt = 0;
    encode_word(32'h44444444, 1'b0, 1'b0);
    chk("t3_strobes", strobe_cnt, 2);
    chk("t3_data", last_data, 32'hF4F4F4F4);

    // Unwritten symbol 15 sets err; only sym0 bits reach the output.
    encode_word(32'h0F0F0F0F, 1'b0, 1'b0);
    chk("t4_err", err, 1);
    do_flush();
    chk("t4_flush_data", last_data, 32'h00000000);
    chk("t4_flush_bits", last_bits, 6'd4);
    chk("t4_err_sticky", err, 1);

    // Strobes during encode are dropped; flush alongside load is discarded.
    strobe_cnt = 0;
    encode_word(32'h44444444, 1'b1, 1'b1);
    chk("t5_strobes", strobe_cnt, 2);
    chk("t5_data", last_data, 32'hF4F4F4F4);

    // Reset during the second encode cycle.
    encode_word(32'h22222222, 1'b0, 1'b0);
    load = 1'b1; in = 32'h44444444;
    tick();
    load = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_busy", busy, 0);
    chk("t6_ready", output_ready, 0);
    chk("t6_data", output_data, 0);
    chk("t6_bits", output_bits, 0);
    chk("t6_err", err, 0);
    tick();
    rst = 1'b0;
    tick();
    do_flush();
    program_table();

    // Randomized words, occasional table rewrites and flushes.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0)
        write_tbl(4'($urandom_range(0, 4)), 16'($urandom), 5'($urandom_range(1, 16)));
      w = '0;
      for (int j = 0; j < 8; j++) begin
        if ($urandom_range(0, 15) == 0) s = 4'($urandom_range(5, 15));
        else s = 4'($urandom_range(0, 4));
        w = {w[27:0], s};
      end
      encode_word(w, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) do_flush();
    end
    do_flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
